// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset constants and IF/ID record for the fetch stage
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP          = ADDR_W'(4);
  localparam logic [ADDR_W-1:0]  PC_ALIGN_MASK    = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = '0;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP      = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               valid;
  } if_id_t;

  // Instructions are word-aligned, so the two byte-offset bits are forced to zero.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with next-PC selection (redirect > stall > +4)
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_plus4;

  // Modulo-2^32 increment: the top word wraps to zero silently.
  assign pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = align_pc(redirect_target_i);
    end else if (!stall_i) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= align_pc(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register, misalign pulse, fetch counter
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               misalign_err,
  output logic [31:0]        fetch_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;

  if_id_t      if_id_q, if_id_d;
  logic [31:0] count_q, count_d;
  logic        misalign_q, misalign_d;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pc_o              (pc),
    .pc_plus4_o        (pc_plus4)
  );

  assign imem_addr = pc;

  // A redirect flushes IF/ID even when the hazard unit is stalling.
  always_comb begin
    if_id_d    = if_id_q;
    count_d    = count_q;
    misalign_d = redirect_valid && (redirect_target[1:0] != 2'b00);
    if (redirect_valid) begin
      if_id_d = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (!stall) begin
      if_id_d = '{instr: imem_instr, pc_plus4: pc_plus4, valid: 1'b1};
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q    <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if_id_q    <= if_id_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;
  assign misalign_err   = misalign_q;
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Address-tagged instruction memory: word at A reads as {A5, A[23:0]}.
  assign imem_instr = {8'hA5, imem_addr[23:0]};

  fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic valid, input logic mis,
                           input logic [31:0] cnt);
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".pc4"},   if_id_pc_plus4, pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    check({tag, ".mis"},   {31'd0, misalign_err}, {31'd0, mis});
    check({tag, ".cnt"},   fetch_count, cnt);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    #3;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    step();
    check_all("reset_hold", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch from RESET_PC
    step(); check_all("seq1", 32'h04, 32'hA500_0000, 32'h04, 1'b1, 1'b0, 32'd1);
    step(); check_all("seq2", 32'h08, 32'hA500_0004, 32'h08, 1'b1, 1'b0, 32'd2);
    step(); check_all("seq3", 32'h0C, 32'hA500_0008, 32'h0C, 1'b1, 1'b0, 32'd3);
    step(); check_all("seq4", 32'h10, 32'hA500_000C, 32'h10, 1'b1, 1'b0, 32'd4);

    // Stall three cycles at pc=0x10
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_all("stall", 32'h10, 32'hA500_000C, 32'h10, 1'b1, 1'b0, 32'd4);
    end
    stall = 1'b0;
    step(); check_all("resume", 32'h14, 32'hA500_0010, 32'h14, 1'b1, 1'b0, 32'd5);

    // Redirect wins over a simultaneous stall
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    step(); check_all("redir_stall", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
    stall          = 1'b0;
    redirect_valid = 1'b0;
    step(); check_all("after_redir", 32'h44, 32'hA500_0040, 32'h44, 1'b1, 1'b0, 32'd6);

    // Misaligned target: low bits dropped, one-cycle error pulse
    redirect_valid  = 1'b1;
    redirect_target = 32'h43;
    step(); check_all("misalign", 32'h40, 32'h0, 32'h0, 1'b0, 1'b1, 32'd6);
    redirect_valid = 1'b0;
    step(); check_all("misalign_clr", 32'h44, 32'hA500_0040, 32'h44, 1'b1, 1'b0, 32'd7);

    // PC wrap at the top of the address space
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step(); check_all("top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd7);
    redirect_valid = 1'b0;
    step(); check_all("wrap1", 32'h0, 32'hA5FF_FFFC, 32'h0, 1'b1, 1'b0, 32'd8);
    step(); check_all("wrap2", 32'h4, 32'hA500_0000, 32'h4, 1'b1, 1'b0, 32'd9);
    step(); check_all("pre_rst", 32'h8, 32'hA500_0004, 32'h8, 1'b1, 1'b0, 32'd10);

    // Asynchronous reset between edges, while stalled
    stall = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    step(); check_all("rst_held", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    step(); check_all("restart1", 32'h04, 32'hA500_0000, 32'h04, 1'b1, 1'b0, 32'd1);
    step(); check_all("restart2", 32'h08, 32'hA500_0004, 32'h08, 1'b1, 1'b0, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
